timer_multi_dev: RTL and testbench
==================================

# timer_multi_dev

Memory-mapped multi-channel interval timer for the processor's I/O space; the parametrised successor of the single-channel timer device. A shared prescaler generates a tick every `CYCLES_PER_TICK` clocks. `NCH` independent channels each count ticks up to their own limit, and raise ready/overflow flags. A per-channel maskable interrupt is produced and the channel interrupts are OR-reduced onto one IRQ line. It attaches to the same `ld`/`sw`/`addrbus`/`databus` bus as the other devices.

## Interface
- `DBITS`, 32, data/address bus width.
- `NCH`, 4, channel count, legal range 1..16.
- `BASEADDR`, 32'hFFFFF100, address of channel 0.
  - Channel n register block = `BASEADDR + 16*n`.
  - Offsets: +0 CNT, +4 LIM, +8 CTRL.
- `CYCLES_PER_TICK`, 50000, clocks per tick (1 ms at 50 MHz); must be ≥ 2.
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `ld`  in  1  bus read strobe.
- `sw`  in  1  bus write strobe.
- `addrbus`  in  DBITS  byte address.
- `databus`  inout  DBITS  read data (driven by this block) / write data (sampled by this block).
- `TIMERIRQS`  out  NCH  per-channel interrupt, bit n = RDY[n] & IE[n].
- `TIMERIRQ`  out  1  OR of `TIMERIRQS`.

## Operation
- **CTRL bits**
  - bit0 RDY, bit2 OVR, bit8 IE, bit9 EN, bit10 ONESHOT.
  - All other bits read 0 and are ignored on write.
- **Reset (`reset`=0)**
  - Every CNT, LIM, RDY, OVR, IE, ONESHOT and the prescaler go to 0.
  - EN goes to 1, so the block counts by default, as the previous device did.
  - `TIMERIRQS`=0, `TIMERIRQ`=0, `databus` = Z.
  - Reset asserted mid-count aborts the count immediately.
- **Prescaler**
  - `pre` counts 0..CYCLES_PER_TICK-1 and wraps.
  - `tick` is high during the cycle where `pre` = CYCLES_PER_TICK-1.
  - The prescaler runs unconditionally and is not affected by bus writes.
- **Channel update on tick**, for each channel with EN=1 and LIM≠0:
  - If CNT = LIM-1: CNT←0, RDY←1, OVR←OVR|RDY (old RDY). In one-shot mode, EN←0 as well.
  - Otherwise CNT←CNT+1.
- **Idle channels:** LIM=0 or EN=0 → CNT holds and flags never set.
- **Bus write (`sw`=1, address matches channel n)**
  - CNT: loaded only if data < LIM (unsigned); otherwise the write is ignored.
  - LIM: LIM←data, CNT←0.
  - CTRL:
    - RDY and OVR are write-0-to-clear (writing 1 keeps the current value).
    - IE, EN and ONESHOT are loaded from data.
- **Simultaneous tick and write to the same channel**
  - A CNT or LIM write wins over the tick increment for that channel.
  - A tick-generated RDY/OVR set wins over a CTRL clear in the same cycle, so no event is lost.
  - IE/EN/ONESHOT take the written value, except that a one-shot expiry in that cycle forces EN=0.
- **Bus read**
  - `ld`=1 with an address matching any channel register drives that register combinationally onto `databus`.
  - Unmatched addresses, or `ld`=0, leave `databus` at Z.
  - The bus master never asserts `ld` and `sw` together; this block makes no guarantee in that case.
- **Width:** CNT and LIM are DBITS wide, and all compares are unsigned.

## Timing
- Register writes take effect at the `clk` edge where `sw` is sampled; a read in the next cycle returns the new value.
- Read data is combinational, with zero-cycle latency from `ld`/`addrbus`.
- CNT changes on the edge that ends a tick cycle.
  - A channel with LIM=L sets RDY exactly L·CYCLES_PER_TICK clocks after its CNT is cleared, assuming the prescaler is aligned.
  - First-period jitter is up to CYCLES_PER_TICK-1 clocks, because the prescaler is shared.
- `TIMERIRQS`/`TIMERIRQ` are combinational from registered RDY/IE. They rise one clock after the expiring tick edge and fall in the cycle after RDY or IE is cleared.

## Configuration
- **`TIMER_ONESHOT_EN` defined**
  - CTRL bit10 ONESHOT is implemented.
  - In one-shot mode the channel stops (EN←0) at expiry, with CNT=0 and RDY=1.
- **`TIMER_ONESHOT_EN` undefined**
  - Bit10 reads 0 and is ignored on write.
  - All channels are periodic only; the EN bit remains.

## Test plan
All scenarios use NCH=4, CYCLES_PER_TICK=4.
- **Reset:** hold `reset`=0 → every CNT/LIM reads 0, CTRL reads 0x200, `TIMERIRQ`=0. With LIM=0, 100 clocks produce no count.
- **Periodic:** ch1 LIM←3 → RDY set 12 clocks after the LIM write (±3), CNT sequence 0,1,2,0. With IE←1, `TIMERIRQS`=4'b0010. Write CTRL=0x100 → RDY clears and the IRQ drops in the next cycle.
- **Overflow and bad load**
  - ch0 LIM←2, RDY left uncleared through a second expiry → OVR=1.
  - Writing CNT←5 is ignored (CNT stays <2); CNT←1 is accepted.
- **Collision:** a CTRL write clearing RDY on ch2 in the same cycle as ch2's expiry tick → RDY reads 1 afterwards and OVR is set if RDY was already 1.
- **One-shot (`TIMER_ONESHOT_EN`):** ch3 LIM←2, CTRL←0x700 → after one expiry EN reads 0, CNT stays 0, RDY=1, IRQ high; no further counting. Without the macro the same write reads back 0x300 and the channel keeps running.
- **Decode/reset:**
  - A read of `BASEADDR`+0x40 (nonexistent channel) → `databus` Z.
  - Asserting `reset` mid-count clears the state asynchronously, before the next `clk` edge.

Source files
------------

// File: rtl/timer_multi_dev.sv
// timer_multi_dev: NCH-channel memory-mapped interval timer sharing one prescaler, with IRQs OR-reduced onto one line.
// Define TIMER_ONESHOT_EN to implement the CTRL bit10 one-shot mode.
module timer_multi_dev #(
  parameter int DBITS = 32,
  parameter int NCH = 4,
  parameter logic [DBITS-1:0] BASEADDR = 32'hFFFFF100,
  parameter int CYCLES_PER_TICK = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             sw,
  input  logic [DBITS-1:0] addrbus,
  inout  wire  [DBITS-1:0] databus,
  output logic [NCH-1:0]   TIMERIRQS,
  output logic             TIMERIRQ
);
  localparam int PW = $clog2(CYCLES_PER_TICK);
  logic [PW-1:0] pre;
  logic tick, hit;
  logic [DBITS-1:0] cnt [NCH];
  logic [DBITS-1:0] lim [NCH];
  logic [DBITS-1:0] cnt_n [NCH];
  logic [DBITS-1:0] lim_n [NCH];
  logic [NCH-1:0] rdy, ovr, ie, en, os;
  logic [NCH-1:0] rdy_n, ovr_n, ie_n, en_n, os_n;
  logic [NCH-1:0] sel_cnt, sel_lim, sel_ctl, wr_ctl, step, expire;
  logic [DBITS-1:0] rd_data, wdata;
  assign tick = pre == PW'(CYCLES_PER_TICK - 1);
  assign wdata = databus;
  always_comb begin
    sel_cnt = '0;
    sel_lim = '0;
    sel_ctl = '0;
    rd_data = '0;
    hit = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      sel_cnt[n] = addrbus == BASEADDR + DBITS'(16 * n);
      sel_lim[n] = addrbus == BASEADDR + DBITS'(16 * n + 4);
      sel_ctl[n] = addrbus == BASEADDR + DBITS'(16 * n + 8);
      hit = hit | sel_cnt[n] | sel_lim[n] | sel_ctl[n];
      rd_data = sel_cnt[n] ? cnt[n] :
                sel_lim[n] ? lim[n] :
                sel_ctl[n] ? DBITS'({os[n], en[n], ie[n], 5'b0, ovr[n], 1'b0, rdy[n]}) : rd_data;
    end
  end
  assign databus = (ld & hit) ? rd_data : 'z;
  // tick-driven flag sets take priority over write-0-to-clear so no expiry is lost
  always_comb begin
    cnt_n = cnt;
    lim_n = lim;
    rdy_n = rdy;
    ovr_n = ovr;
    ie_n = ie;
    en_n = en;
    os_n = '0;
    wr_ctl = '0;
    step = '0;
    expire = '0;
    for (int n = 0; n < NCH; n++) begin
      wr_ctl[n] = sw & sel_ctl[n];
      step[n] = tick & en[n] & (lim[n] != '0);
      expire[n] = step[n] & (cnt[n] == lim[n] - DBITS'(1));
      cnt_n[n] = (sw & sel_lim[n]) ? '0 :
                 (sw & sel_cnt[n] & (wdata < lim[n])) ? wdata :
                 expire[n] ? '0 :
                 step[n] ? cnt[n] + DBITS'(1) : cnt[n];
      lim_n[n] = (sw & sel_lim[n]) ? wdata : lim[n];
      rdy_n[n] = expire[n] | (rdy[n] & ~(wr_ctl[n] & ~wdata[0]));
      ovr_n[n] = (expire[n] & rdy[n]) | (ovr[n] & ~(wr_ctl[n] & ~wdata[2]));
      ie_n[n] = wr_ctl[n] ? wdata[8] : ie[n];
      en_n[n] = ~(expire[n] & os[n]) & (wr_ctl[n] ? wdata[9] : en[n]);
`ifdef TIMER_ONESHOT_EN
      os_n[n] = wr_ctl[n] ? wdata[10] : os[n];
`else
      os_n[n] = 1'b0;
`endif
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      rdy <= '0;
      ovr <= '0;
      ie <= '0;
      en <= '1;
      os <= '0;
      for (int n = 0; n < NCH; n++) begin
        cnt[n] <= '0;
        lim[n] <= '0;
      end
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      cnt <= cnt_n;
      lim <= lim_n;
      rdy <= rdy_n;
      ovr <= ovr_n;
      ie <= ie_n;
      en <= en_n;
      os <= os_n;
    end
  end
  assign TIMERIRQS = rdy & ie;
  assign TIMERIRQ = |TIMERIRQS;
endmodule

// File: tb/tb_timer_multi_dev.sv
// tb_timer_multi_dev: register table plus hand-built timing sequences for the multi-channel timer.
module tb_timer_multi_dev;
  localparam logic [31:0] B = 32'hFFFFF100;
`ifdef TIMER_ONESHOT_EN
  localparam bit OS = 1'b1;
`else
  localparam bit OS = 1'b0;
`endif
  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;
  logic clk = 1'b0, reset = 1'b0, ld = 1'b0, sw = 1'b0, drv = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  wire [31:0] databus;
  logic [3:0] irqs;
  logic irq;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [31:0] sb_q[$];
  assign databus = drv ? wdat : 'z;
  timer_multi_dev #(.DBITS(32), .NCH(4), .BASEADDR(B), .CYCLES_PER_TICK(4)) dut (
    .clk(clk), .reset(reset), .ld(ld), .sw(sw), .addrbus(addr),
    .databus(databus), .TIMERIRQS(irqs), .TIMERIRQ(irq)
  );
  always #5 clk = ~clk;
  // mirrors the prescaler phase: after cyc clocks out of reset, pre = cyc % 4
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr = a;
    wdat = d;
    drv = 1'b1;
    sw = 1'b1;
    @(negedge clk);
    sw = 1'b0;
    drv = 1'b0;
  endtask
  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    addr = a;
    ld = 1'b1;
    #1;
    v = databus;
    ld = 1'b0;
  endtask
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    logic [31:0] exp;
    addr = a;
    ld = 1'b1;
    sb_q.push_back(e);
    #1;
    exp = sb_q.pop_front();
    cmp(nm, databus, exp);
    ld = 1'b0;
  endtask
  task automatic chk_z(input string nm, input logic [31:0] a);
    logic [31:0] v;
    rd(a, v);
    cmp(nm, 32'((v === 32'bz) || (v === 32'h0)), 32'd1);
  endtask
  task automatic wait_rdy(input logic [31:0] a, input string nm, output int n);
    logic [31:0] v;
    bit ok;
    ok = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      rd(a, v);
      if (v[0]) ok = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    cmp({nm, "_seen"}, 32'(ok), 32'd1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tbl[9];
    logic [31:0] v, last;
    logic [31:0] seq[$];
    logic [31:0] pexp[4];
    int n;
    bit found;
    tbl[0] = '{B + 8, 32'hFFFFFFFF, B + 8, OS ? 32'h700 : 32'h300};
    tbl[1] = '{B + 8, 32'h0, B + 8, 32'h0};
    tbl[2] = '{B + 24, 32'h100, B + 24, 32'h100};
    tbl[3] = '{B + 16, 32'h7, B + 16, 32'h0};
    tbl[4] = '{B + 36, 32'h0, B + 36, 32'h0};
    tbl[5] = '{B + 56, 32'h5, B + 56, 32'h0};
    tbl[6] = '{B + 56, 32'h200, B + 56, 32'h200};
    tbl[7] = '{B + 8, 32'h200, B + 8, 32'h200};
    tbl[8] = '{B + 24, 32'h200, B + 24, 32'h200};
    pexp = '{32'd0, 32'd1, 32'd2, 32'd0};
    repeat (3) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("rst_cnt%0d", c), B + 32'(16 * c), 32'h0);
      chk($sformatf("rst_lim%0d", c), B + 32'(16 * c + 4), 32'h0);
      chk($sformatf("rst_ctl%0d", c), B + 32'(16 * c + 8), 32'h200);
    end
    cmp("rst_irq", 32'(irq), 32'h0);
    cmp("rst_irqs", 32'(irqs), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    for (int c = 0; c < 4; c++) chk($sformatf("idle_cnt%0d", c), B + 32'(16 * c), 32'h0);
    for (int i = 0; i < 9; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      chk($sformatf("vec%0d", i), tbl[i].raddr, tbl[i].exp);
    end
    @(negedge clk);
    wr(B + 20, 32'd3);
    last = 32'hFFFFFFFF;
    found = 1'b0;
    n = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      rd(B + 16, v);
      if (v != last) begin
        seq.push_back(v);
        last = v;
      end
      rd(B + 24, v);
      if (v[0]) found = 1'b1;
      else begin
        @(negedge clk);
        n++;
      end
    end
    cmp("per_seen", 32'(found), 32'd1);
    cmp("per_latency_9_15", 32'(n >= 9 && n <= 15), 32'd1);
    cmp("per_seq_len", 32'(seq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      cmp($sformatf("per_seq%0d", i), (i < seq.size()) ? seq[i] : 32'hDEADBEEF, pexp[i]);
    wr(B + 24, 32'h301);
    cmp("per_irqs", 32'(irqs), 32'h2);
    cmp("per_irq", 32'(irq), 32'h1);
    wr(B + 24, 32'h100);
    cmp("per_irq_drop", 32'(irq), 32'h0);
    chk("per_ctl_clr", B + 24, 32'h100);
    wr(B + 4, 32'd2);
    wait_rdy(B + 8, "ovr_first", n);
    chk("ovr_first_ctl", B + 8, 32'h201);
    repeat (12) @(negedge clk);
    chk("ovr_second_ctl", B + 8, 32'h205);
    wr(B + 8, 32'h5);
    chk("ovr_stop_ctl", B + 8, 32'h5);
    wr(B + 0, 32'd0);
    chk("load0", B + 0, 32'd0);
    wr(B + 0, 32'd5);
    chk("load5_ignored", B + 0, 32'd0);
    wr(B + 0, 32'd1);
    chk("load1", B + 0, 32'd1);
    wr(B + 0, 32'd2);
    chk("load_eq_lim_ignored", B + 0, 32'd1);
    wr(B + 36, 32'd2);
    wait_rdy(B + 40, "coll_first", n);
    chk("coll_first_ctl", B + 40, 32'h201);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      rd(B + 32, v);
      if (v == 32'd1 && cyc % 4 == 3) found = 1'b1;
      else @(negedge clk);
    end
    cmp("coll_found", 32'(found), 32'd1);
    wr(B + 40, 32'h200);
    chk("coll_ctl", B + 40, 32'h205);
    wr(B + 52, 32'd2);
    wr(B + 56, 32'h700);
    chk("os_ctl_wr", B + 56, OS ? 32'h700 : 32'h300);
    wait_rdy(B + 56, "os_exp", n);
    chk("os_ctl_exp", B + 56, OS ? 32'h501 : 32'h301);
    chk("os_cnt_exp", B + 48, 32'd0);
    cmp("os_irqs", 32'(irqs), 32'h8);
    cmp("os_irq", 32'(irq), 32'h1);
    repeat (20) @(negedge clk);
    chk("os_ctl_later", B + 56, OS ? 32'h501 : 32'h305);
    if (OS) chk("os_cnt_later", B + 48, 32'd0);
    chk_z("dec_ch4", B + 32'h40);
    chk_z("dec_off12", B + 32'hC);
    chk_z("dec_noload", 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("arst_lim2", B + 36, 32'h0);
    chk("arst_ctl2", B + 40, 32'h200);
    chk("arst_ctl3", B + 56, 32'h200);
    cmp("arst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
